// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus: single-outstanding request/grant/response.
// The master modport is the fetch sequencer; the slave modport is the memory.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding fetch at a
// time, holds the fetched word in a one-entry valid/ready register for decode,
// and applies exception/redirect with squash of in-flight fetches.
// Optional macro FETCH_CTRL_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180
) (
    input  logic                clk,
    input  logic                rst,
    fetch_ctrl_if.master        imem,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    input  logic                if_ready,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                exc,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_squashed,
`endif
    output logic [31:0]         pc
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        capture;
    logic        flush;
    logic [31:0] flush_pc;

    // Exception wins over redirect; targets are forced word-aligned.
    assign flush    = exc | redirect;
    assign flush_pc = exc ? EXC_VEC : (redirect_pc & 32'hFFFF_FFFC);

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    // The output register holds a valid word exactly while parked in HOLD.
    assign if_valid       = (state_q == HOLD);

    // Next-state and next-PC selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    pc_d = flush_pc;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    // A granted request leaves a response in flight that must be drained.
                    state_d = imem.imem_gnt ? DRAIN : IDLE;
                end else if (imem.imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = imem.imem_rvalid ? IDLE : DRAIN;
                end else if (imem.imem_rvalid) begin
                    capture = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = IDLE;
                end else if (if_ready) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem.imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and output-register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_VEC;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                if_instr <= imem.imem_rdata;
                if_pc    <= pc_q;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic fire;
    logic squash;

    assign fire   = if_valid && if_ready;
    // A squash discards something only when a valid word or a not-yet-drained
    // response exists; a flush in DRAIN re-targets an already-discarded fetch.
    assign squash = flush && ((state_q == HOLD) || (state_q == WAIT) ||
                              ((state_q == REQ) && imem.imem_gnt));

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched  <= 32'h0;
            perf_squashed <= 32'h0;
        end else begin
            if (fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (squash) begin
                perf_squashed <= perf_squashed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl plus hand-written sequences for
// asynchronous reset and first-fetch latency.
module tb_fetch_ctrl;

    localparam logic [31:0] EV   = 32'h8000_0180;
    localparam logic [31:0] I0   = 32'h1111_0000;
    localparam logic [31:0] I1   = 32'h2222_0004;
    localparam logic [31:0] I2   = 32'h3333_0008;
    localparam logic [31:0] I3   = 32'h4444_000C;
    localparam logic [31:0] I4   = 32'h5555_1000;
    localparam logic [31:0] I5   = 32'h6666_FFFC;
    localparam logic [31:0] I6   = 32'h7777_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc;
    logic [31:0] pc;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_VEC(32'h0000_0000), .EXC_VEC(EV)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus.master),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc         (exc),
`ifdef FETCH_CTRL_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed),
`endif
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exc;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ifpc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic rdr, input logic [31:0] rpc,
                                input logic ex, input logic e_req, input logic e_val,
                                input logic [31:0] e_ins, input logic [31:0] e_ifpc,
                                input logic [31:0] e_pc);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rdr; v.rpc = rpc;
        v.exc = ex; v.e_req = e_req; v.e_valid = e_val; v.e_instr = e_ins;
        v.e_ifpc = e_ifpc; v.e_pc = e_pc;
        vecs.push_back(v);
    endfunction

    initial begin
        int cycles;

        // Inputs per cycle | outputs expected just after that cycle's rising edge.
        //  gnt rv rdata rdy rd  rpc            exc | req val instr ifpc          pc
        // Sequential fetch with immediate grant and next-cycle response.
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, 0,  0,            0);            // IDLE->REQ
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, 0,  0,            0);            // ->WAIT
        add(1, 1, I0,   1, 0, 0,             0,  0, 1, I0, 0,            4);            // ->HOLD
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I0, 0,            4);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I0, 0,            4);
        add(1, 1, I1,   1, 0, 0,             0,  0, 1, I1, 4,            8);
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I1, 4,            8);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I1, 4,            8);
        add(1, 1, I2,   1, 0, 0,             0,  0, 1, I2, 8,            32'hC);
        // Decode stalls five cycles: everything frozen, pc = if_pc + 4.
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 0, 0, 0,            0,  0, 1, I2, 8,            32'hC);
        add(0, 0, 0,    1, 0, 0,             0,  1, 0, I2, 8,            32'hC);        // ->REQ
        // Grant withheld four cycles: request and address held.
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 1, 0, 0,            0,  1, 0, I2, 8,            32'hC);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I2, 8,            32'hC);
        add(1, 1, I3,   1, 0, 0,             0,  0, 1, I3, 32'hC,        32'h10);
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I3, 32'hC,        32'h10);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I3, 32'hC,        32'h10);       // WAIT
        // Redirect in WAIT to unaligned target; late response dropped.
        add(0, 0, 0,    1, 1, 32'h1003,      0,  0, 0, I3, 32'hC,        32'h1000);     // ->DRAIN
        add(0, 0, 0,    1, 0, 0,             0,  0, 0, I3, 32'hC,        32'h1000);
        add(0, 1, JUNK, 1, 0, 0,             0,  0, 0, I3, 32'hC,        32'h1000);     // ->IDLE
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I3, 32'hC,        32'h1000);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I3, 32'hC,        32'h1000);
        add(1, 1, I4,   0, 0, 0,             0,  0, 1, I4, 32'h1000,     32'h1004);
        // exc + redirect + transfer in the same cycle: exception wins.
        add(0, 0, 0,    1, 1, 32'h40,        1,  0, 0, I4, 32'h1000,     EV);
        add(0, 0, 0,    1, 0, 0,             0,  1, 0, I4, 32'h1000,     EV);
        // Redirect in REQ without grant: req drops a cycle.
        add(0, 0, 0,    1, 1, 32'hFFFF_FFFC, 0,  0, 0, I4, 32'h1000,     32'hFFFF_FFFC);
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I4, 32'h1000,     32'hFFFF_FFFC);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I4, 32'h1000,     32'hFFFF_FFFC);
        add(1, 1, I5,   0, 0, 0,             0,  0, 1, I5, 32'hFFFF_FFFC, 0);           // wrap
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I5, 32'hFFFF_FFFC, 0);
        // Redirect in REQ with grant: drain the in-flight response.
        add(1, 0, 0,    1, 1, 32'h200,       0,  0, 0, I5, 32'hFFFF_FFFC, 32'h200);     // ->DRAIN
        add(0, 1, JUNK, 1, 0, 0,             0,  0, 0, I5, 32'hFFFF_FFFC, 32'h200);     // ->IDLE
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I5, 32'hFFFF_FFFC, 32'h200);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I5, 32'hFFFF_FFFC, 32'h200);
        // Exception with response arriving: discarded, no increment.
        add(0, 1, JUNK, 1, 0, 0,             1,  0, 0, I5, 32'hFFFF_FFFC, EV);
        add(1, 0, 0,    1, 0, 0,             0,  1, 0, I5, 32'hFFFF_FFFC, EV);
        add(1, 0, 0,    1, 0, 0,             0,  0, 0, I5, 32'hFFFF_FFFC, EV);          // WAIT

        // Reset state, applied asynchronously before any clock edge.
        rst = 1'b0;
        if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; exc = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        #1;
        check("reset_pc",    pc,                        32'h0);
        check("reset_req",   {31'h0, bus.imem_req},     32'h0);
        check("reset_valid", {31'h0, if_valid},         32'h0);
        check("reset_instr", if_instr,                  32'h0);
        check("reset_ifpc",  if_pc,                     32'h0);
`ifdef FETCH_CTRL_PERF_EN
        check("reset_perf_f", perf_fetched,  32'h0);
        check("reset_perf_s", perf_squashed, 32'h0);
`endif

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.imem_gnt     = vecs[i].gnt;
            bus.imem_rvalid  = vecs[i].rv;
            bus.imem_rdata   = vecs[i].rdata;
            if_ready         = vecs[i].rdy;
            redirect         = vecs[i].redir;
            redirect_pc      = vecs[i].rpc;
            exc              = vecs[i].exc;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_req", i),   {31'h0, bus.imem_req}, {31'h0, vecs[i].e_req});
            check($sformatf("v%0d_valid", i), {31'h0, if_valid},     {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_instr", i), if_instr,              vecs[i].e_instr);
            check($sformatf("v%0d_ifpc", i),  if_pc,                 vecs[i].e_ifpc);
            check($sformatf("v%0d_pc", i),    pc,                    vecs[i].e_pc);
            check($sformatf("v%0d_addr", i),  bus.imem_addr,         vecs[i].e_pc);
            @(negedge clk);
        end
`ifdef FETCH_CTRL_PERF_EN
        check("perf_fetched",  perf_fetched,  32'd6);
        check("perf_squashed", perf_squashed, 32'd4);
`endif

        // Reset dropped while in WAIT takes effect without a clock edge.
        rst = 1'b0;
        #1;
        check("async_pc",    pc,                    32'h0);
        check("async_req",   {31'h0, bus.imem_req}, 32'h0);
        check("async_valid", {31'h0, if_valid},     32'h0);
        check("async_instr", if_instr,              32'h0);
`ifdef FETCH_CTRL_PERF_EN
        check("async_perf_f", perf_fetched,  32'h0);
        check("async_perf_s", perf_squashed, 32'h0);
`endif

        // First fetch after reset release: if_valid three edges later.
        @(negedge clk);
        @(negedge clk);
        bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = I6;
        if_ready = 1'b0; redirect = 1'b0; exc = 1'b0;
        rst = 1'b1;
        cycles = 0;
        while (!if_valid && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("first_latency", cycles,   32'd3);
        check("first_instr",   if_instr, I6);
        check("first_ifpc",    if_pc,    32'h0);
        check("first_pc",      pc,       32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
